// File: rtl/fallthrough_fifo_packer.sv
// Packs RATIO consecutive words from a fallthrough FIFO into one wide valid/ready beat.
// A word flagged last closes the beat early; keeps word and packet statistics counters.
module fallthrough_fifo_packer #(
  parameter int WIDTH    = 72,
  parameter int RATIO    = 4,
  parameter int CNT_BITS = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         fifo_dout,
  input  logic                     fifo_last,
  input  logic                     fifo_empty,
  output logic                     fifo_rd_en,
  output logic [WIDTH*RATIO-1:0]   out_data,
  output logic [RATIO-1:0]         out_keep,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_BITS-1:0]      word_count,
  output logic [CNT_BITS-1:0]      pkt_count
);

  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  typedef enum logic {FILL, STALL} state_t;

  state_t                 state, state_next;
  logic [IDX_W-1:0]       idx;
  logic [WIDTH*RATIO-1:0] acc_data, merged_data;
  logic [RATIO-1:0]       acc_keep, merged_keep;
  logic                   acc_last;
  logic                   rd, out_free, complete, load_direct, load_stall;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= FILL;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (complete && !out_free) state_next = STALL;
      STALL:   if (out_ready)             state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_comb begin
    rd         = 1'b0;
    load_stall = 1'b0;
    case (state)
      FILL:    rd         = reset_n && !fifo_empty;
      STALL:   load_stall = reset_n && out_ready;
      default: ;
    endcase
  end

  assign fifo_rd_en  = rd;
  assign out_free    = !out_valid || out_ready;
  assign complete    = rd && ((idx == LAST_IDX) || fifo_last);
  assign load_direct = complete && out_free;

  // Accumulator with the incoming word already placed in lane idx; this lets a
  // completing word bypass the accumulator straight into the output register.
  always_comb begin
    merged_data = acc_data;
    merged_keep = acc_keep;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (idx == IDX_W'(i)) begin
        merged_data[i*WIDTH +: WIDTH] = fifo_dout;
        merged_keep[i]                = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (load_direct) begin
      out_data  <= merged_data;
      out_keep  <= merged_keep;
      out_last  <= fifo_last;
      out_valid <= 1'b1;
    end else if (load_stall) begin
      out_data  <= acc_data;
      out_keep  <= acc_keep;
      out_last  <= acc_last;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || load_direct || load_stall) begin
      acc_data <= '0;
      acc_keep <= '0;
      acc_last <= 1'b0;
      idx      <= '0;
    end else if (rd) begin
      acc_data <= merged_data;
      acc_keep <= merged_keep;
      acc_last <= fifo_last;
      if (!complete) idx <= idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      word_count <= '0;
      pkt_count  <= '0;
    end else begin
      word_count <= word_count + CNT_BITS'(rd);
      if (out_valid && out_ready && out_last) pkt_count <= pkt_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fallthrough_fifo_packer.sv
// Bench for fallthrough_fifo_packer: a FIFO queue plus a transaction-level packer model,
// compared every cycle, with directed scenarios followed by randomized traffic.
module tb_fallthrough_fifo_packer;

  localparam int W = 16;
  localparam int R = 4;
  localparam int C = 4;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } word_t;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [W-1:0]   fifo_dout;
  logic           fifo_last;
  logic           fifo_empty;
  logic           fifo_rd_en;
  logic [W*R-1:0] out_data;
  logic [R-1:0]   out_keep;
  logic           out_last;
  logic           out_valid;
  logic           out_ready;
  logic [C-1:0]   word_count;
  logic [C-1:0]   pkt_count;

  fallthrough_fifo_packer #(.WIDTH(W), .RATIO(R), .CNT_BITS(C)) dut (
    .clk(clk), .reset_n(reset_n),
    .fifo_dout(fifo_dout), .fifo_last(fifo_last), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .word_count(word_count), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;

  word_t        fq[$];
  logic [W-1:0] m_acc[$];
  logic         hold;
  logic         m_out_valid, m_out_last, m_pend, m_pend_last;
  logic [W*R-1:0] m_out_data, m_pend_data;
  logic [R-1:0] m_out_keep, m_pend_keep;
  logic [C-1:0] m_wc, m_pc;
  int           rd_hits, rd_run, rd_max;
  logic         seen15;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic m_reset();
    m_acc.delete();
    m_out_valid = 0; m_out_last = 0; m_out_data = '0; m_out_keep = '0;
    m_pend = 0; m_pend_last = 0; m_pend_data = '0; m_pend_keep = '0;
    m_wc = '0; m_pc = '0;
  endtask

  // Effect of one clock edge, derived from the transaction rules of the packer.
  task automatic model_edge();
    logic xfer, free, loaded;
    logic [W*R-1:0] nd;
    logic [R-1:0] nk;
    word_t w;
    if (!reset_n) begin m_reset(); return; end
    xfer = m_out_valid && out_ready;
    free = !m_out_valid || out_ready;
    loaded = 0;
    if (xfer && m_out_last) m_pc++;
    if (m_pend) begin
      if (out_ready) begin
        m_out_data = m_pend_data; m_out_keep = m_pend_keep; m_out_last = m_pend_last;
        m_out_valid = 1; m_pend = 0; loaded = 1;
      end
    end else if (!fifo_empty) begin
      w = fq.pop_front();
      m_wc++;
      m_acc.push_back(w.d);
      if (m_acc.size() == R || w.l) begin
        nd = '0; nk = '0;
        for (int i = 0; i < m_acc.size(); i++) begin
          nd[i*W +: W] = m_acc[i];
          nk[i] = 1'b1;
        end
        m_acc.delete();
        if (free) begin
          m_out_data = nd; m_out_keep = nk; m_out_last = w.l; m_out_valid = 1; loaded = 1;
        end else begin
          m_pend_data = nd; m_pend_keep = nk; m_pend_last = w.l; m_pend = 1;
        end
      end
    end
    if (!loaded && xfer) m_out_valid = 0;
  endtask

  // One cycle: drive at negedge, check fifo_rd_en mid-cycle, then registered outputs.
  task automatic cycle();
    logic exp_rd;
    fifo_empty = hold || (fq.size() == 0);
    fifo_dout  = (fq.size() != 0) ? fq[0].d : '0;
    fifo_last  = (fq.size() != 0) ? fq[0].l : 1'b0;
    #1;
    exp_rd = reset_n && !m_pend && !fifo_empty;
    check("fifo_rd_en", fifo_rd_en, exp_rd);
    if (fifo_rd_en) begin rd_hits++; rd_run++; if (rd_run > rd_max) rd_max = rd_run; end
    else rd_run = 0;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check("out_valid", out_valid, m_out_valid);
    check("word_count", word_count, m_wc);
    check("pkt_count", pkt_count, m_pc);
    if (word_count == 4'd15) seen15 = 1;
    if (m_out_valid) begin
      check("out_data", out_data, m_out_data);
      check("out_keep", out_keep, m_out_keep);
      check("out_last", out_last, m_out_last);
    end
  endtask

  task automatic push(input logic [W-1:0] d, input logic l);
    word_t w;
    w.d = d; w.l = l;
    fq.push_back(w);
  endtask

  task automatic do_reset();
    reset_n = 0;
    fq.delete();
    cycle();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_keep", out_keep, 0);
    check("rst_out_last", out_last, 0);
    check("rst_word_count", word_count, 0);
    check("rst_pkt_count", pkt_count, 0);
    reset_n = 1;
  endtask

  initial begin
    reset_n = 0; out_ready = 0; hold = 0; seen15 = 0;
    fifo_empty = 1; fifo_dout = '0; fifo_last = 0;
    rd_hits = 0; rd_run = 0; rd_max = 0;
    m_reset();
    @(negedge clk);
    do_reset();

    // Eight words, no last, sink always ready
    out_ready = 1;
    for (int i = 1; i <= 8; i++) push(W'(i), 1'b0);
    for (int i = 0; i < 12; i++) cycle();
    check("t1_rd_hits", rd_hits, 8);
    check("t1_rd_consecutive", rd_max, 8);
    check("t1_word_count", word_count, 8);

    // Short packet A,B with last on B
    push(16'hAAAA, 1'b0); push(16'hBBBB, 1'b1);
    cycle(); cycle();
    check("t2_data", out_data, 64'h0000_0000_BBBB_AAAA);
    check("t2_keep", out_keep, 4'b0011);
    check("t2_last", out_last, 1);
    cycle();
    check("t2_pkt_count", pkt_count, 1);

    // Blocked sink: first beat held, second group fills, then stall
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 12; i++) push(W'(16'h100 + i), 1'b0);
    for (int i = 0; i < 12; i++) cycle();
    check("t3_stall_rd_en", fifo_rd_en, 0);
    check("t3_word_count", word_count, 8);
    check("t3_held_data", out_data, 64'h0103_0102_0101_0100);
    out_ready = 1;
    for (int i = 0; i < 10; i++) cycle();

    // Single-word packet, then back-to-back packets with a toggling sink
    push(16'h5A5A, 1'b1);
    for (int i = 0; i < 3; i++) push(W'(16'h200 + i), i == 2);
    for (int i = 0; i < 6; i++) push(W'(16'h300 + i), i == 5);
    for (int i = 0; i < 30; i++) begin
      out_ready = (i % 3) != 1;
      cycle();
    end

    // Reset while a beat is pending and two lanes are filled
    out_ready = 0;
    for (int i = 0; i < 6; i++) push(W'(16'h400 + i), 1'b0);
    for (int i = 0; i < 6; i++) cycle();
    check("t5_pre_valid", out_valid, 1);
    do_reset();
    out_ready = 1;
    push(16'h0E0E, 1'b0); push(16'h0F0F, 1'b1);
    cycle(); cycle();
    check("t5_lane0_data", out_data, 64'h0000_0000_0F0F_0E0E);

    // Counter wrap: 17 words
    do_reset();
    seen15 = 0;
    for (int i = 0; i < 17; i++) push(W'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) cycle();
    check("t6_seen15", seen15, 1);
    check("t6_wrap", word_count, 1);

    // Randomized traffic with FIFO gaps and sink backpressure
    for (int i = 0; i < 600; i++) begin
      if (fq.size() < 20 && ($urandom % 3) != 0) push(W'($urandom), ($urandom % 4) == 0);
      out_ready = ($urandom % 2) == 1;
      hold = ($urandom % 5) == 0;
      cycle();
    end
    hold = 0; out_ready = 1;
    for (int i = 0; i < 40; i++) cycle();
    check("drained", fq.size(), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
